// File: rtl/pow_n_en_pipelined_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined n**POW block.
package pow_n_en_pipelined_pkg;

    localparam int MIN_W   = 1;
    localparam int MIN_POW = 1;

    function automatic bit params_ok(input int w, input int pow);
        return (w >= MIN_W) && (pow >= MIN_POW);
    endfunction

    // Full-precision width of a W x W product.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/pow_n_en_pipelined_stage.sv
// One multiply stage: acc*n truncated to W bits, sticky overflow when the high half is non-zero.
module pow_n_stage
    import pow_n_en_pipelined_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic         i_vld,
    input  logic [W-1:0] i_n,
    input  logic [W-1:0] i_acc,
    input  logic         i_ovf,
    output logic         o_vld,
    output logic [W-1:0] o_n,
    output logic [W-1:0] o_acc,
    output logic         o_ovf
);

    localparam int PW = prod_width(W);

    logic [PW-1:0] w_prod;
    logic [W-1:0]  w_hi;
    logic [W-1:0]  w_lo;
    logic          r_vld;
    logic [W-1:0]  r_n;
    logic [W-1:0]  r_acc;
    logic          r_ovf;

    assign w_prod = PW'(i_acc) * PW'(i_n);
    assign w_hi   = w_prod[PW-1:W];
    assign w_lo   = w_prod[W-1:0];

    // Valid bit: the only state that is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
        end else if (clk_en) begin
            r_vld <= i_vld;
        end
    end

    // Data path loads on every enabled edge regardless of valid.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            r_n   <= i_n;
            r_acc <= w_lo;
            r_ovf <= i_ovf | (w_hi != {W{1'b0}});
        end
    end

    assign o_vld = r_vld;
    assign o_n   = r_n;
    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/pow_n_en_pipelined.sv
// Fully pipelined n**POW mod 2**W with global clock enable, overflow flag and busy indication.
module pow_n_en_pipelined
    import pow_n_en_pipelined_pkg::*;
#(
    parameter int W   = 8,
    parameter int POW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic         n_vld,
    input  logic [W-1:0] n,
    output logic         res_vld,
    output logic [W-1:0] res,
    output logic         res_ovf,
    output logic         busy
);

    generate
        if (!params_ok(W, POW)) begin : g_param_err
            $error("pow_n_en_pipelined: W and POW must both be >= 1");
        end
    endgenerate

    logic [POW-1:0]        w_vld;
    logic [POW-1:0][W-1:0] w_n;
    logic [POW-1:0][W-1:0] w_acc;
    logic [POW-1:0]        w_ovf;
    logic                  r_vld0;
    logic [W-1:0]          r_n0;
    logic                  r_ovf0;
    logic                  w_unused;

    // Stage 0 valid: captures the operand strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld0 <= 1'b0;
        end else if (clk_en) begin
            r_vld0 <= n_vld;
        end
    end

    // Stage 0 data: acc starts as n itself, so stage k holds n**(k+1).
    always_ff @(posedge clk) begin
        if (clk_en) begin
            r_n0   <= n;
            r_ovf0 <= 1'b0;
        end
    end

    assign w_vld[0] = r_vld0;
    assign w_n[0]   = r_n0;
    assign w_acc[0] = r_n0;
    assign w_ovf[0] = r_ovf0;

    generate
        for (genvar k = 1; k < POW; k++) begin : g_stage
            pow_n_stage #(.W(W)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .clk_en (clk_en),
                .i_vld  (w_vld[k-1]),
                .i_n    (w_n[k-1]),
                .i_acc  (w_acc[k-1]),
                .i_ovf  (w_ovf[k-1]),
                .o_vld  (w_vld[k]),
                .o_n    (w_n[k]),
                .o_acc  (w_acc[k]),
                .o_ovf  (w_ovf[k])
            );
        end
    endgenerate

    // The last stage's operand copy has no consumer.
    assign w_unused = ^w_n[POW-1];

    assign res_vld = w_vld[POW-1];
    assign res     = w_acc[POW-1];
    assign res_ovf = w_ovf[POW-1];
    assign busy    = |w_vld;

endmodule

// File: tb/tb_pow_n_en_pipelined.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based power model.
module tb_pow_n_en_pipelined;

    localparam int W = 8;
    localparam int P = 5;

    typedef struct {
        logic [7:0] n;
        int         idx;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en, n_vld;
    logic [7:0] n;
    logic       res_vld, res_ovf, busy;
    logic [7:0] res;

    logic       a_en, a_vld;
    logic [7:0] a_n;
    logic       r1_vld, r1_ovf, b1;
    logic [7:0] r1;
    logic       r2_vld, r2_ovf, b2;
    logic [7:0] r2;

    int n_cmp = 0;
    int n_bad = 0;

    op_t        q[$];
    int         en_cnt = 0;
    logic       exp_vld = 1'b0;
    logic       exp_ovf = 1'b0;
    logic       exp_busy = 1'b0;
    logic [7:0] exp_res = 8'd0;

    always #5 clk = ~clk;

    pow_n_en_pipelined #(.W(W), .POW(P)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .n_vld(n_vld), .n(n),
        .res_vld(res_vld), .res(res), .res_ovf(res_ovf), .busy(busy)
    );

    pow_n_en_pipelined #(.W(W), .POW(1)) d1 (
        .clk(clk), .rst_n(rst_n), .clk_en(a_en), .n_vld(a_vld), .n(a_n),
        .res_vld(r1_vld), .res(r1), .res_ovf(r1_ovf), .busy(b1)
    );

    pow_n_en_pipelined #(.W(W), .POW(2)) d2 (
        .clk(clk), .rst_n(rst_n), .clk_en(a_en), .n_vld(a_vld), .n(a_n),
        .res_vld(r2_vld), .res(r2), .res_ovf(r2_ovf), .busy(b2)
    );

    // True integer power; overflow means the exact value exceeds 8 bits.
    function automatic void pow_ref(input logic [7:0] b, input int p,
                                    output logic [7:0] r, output logic o);
        longint unsigned v;
        v = 64'd1;
        for (int i = 0; i < p; i++) v = v * longint'(b);
        r = v[7:0];
        o = (v > 64'd255);
    endfunction

    // One clock of the main DUT; the model advances only on enabled edges.
    task automatic drive(input bit en, input bit vld, input logic [7:0] nn);
        op_t o;
        @(negedge clk);
        clk_en = en;
        n_vld  = vld;
        n      = nn;
        @(posedge clk);
        #1;
        if (en) begin
            en_cnt++;
            if (vld) begin
                o.n   = nn;
                o.idx = en_cnt;
                q.push_back(o);
            end
            exp_vld = 1'b0;
            if (q.size() > 0 && q[0].idx + P - 1 == en_cnt) begin
                pow_ref(q[0].n, P, exp_res, exp_ovf);
                exp_vld = 1'b1;
                void'(q.pop_front());
            end
        end
        exp_busy = exp_vld || (q.size() > 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; n_vld = 1'b0; n = 8'd0;
        a_en = 1'b1; a_vld = 1'b0; a_n = 8'd0;
        #1;
        n_cmp++;
        if (res_vld !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_main: res_vld=%b busy=%b expected 0 0", res_vld, busy);
        end
        n_cmp++;
        if (r1_vld !== 1'b0 || b1 !== 1'b0 || r2_vld !== 1'b0 || b2 !== 1'b0) begin
            n_bad++; $display("FAIL reset_aux: vld1=%b busy1=%b vld2=%b busy2=%b expected all 0",
                              r1_vld, b1, r2_vld, b2);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 1'b1, 8'd3);
        n_cmp++;
        if (res_vld !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL single_accept: res_vld=%b busy=%b expected 0 1", res_vld, busy);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 8'd0);
            n_cmp++;
            if (i < 4) begin
                if (res_vld !== 1'b0) begin
                    n_bad++; $display("FAIL single_early: edge %0d res_vld=%b expected 0", i, res_vld);
                end
            end else if (res_vld !== 1'b1 || res !== 8'd243 || res_ovf !== 1'b0) begin
                n_bad++; $display("FAIL single_result: vld=%b res=%0d ovf=%b expected 1 243 0",
                                  res_vld, res, res_ovf);
            end
        end
        drive(1'b1, 1'b0, 8'd0);
    endtask

    task automatic test_ovf();
        drive(1'b1, 1'b1, 8'd4);
        drive(1'b1, 1'b1, 8'd2);
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b0, 8'd0);
            if (j == 2) begin
                n_cmp++;
                if (res_vld !== 1'b1 || res !== 8'd0 || res_ovf !== 1'b1) begin
                    n_bad++; $display("FAIL ovf_4: vld=%b res=%0d ovf=%b expected 1 0 1", res_vld, res, res_ovf);
                end
            end else if (j == 3) begin
                n_cmp++;
                if (res_vld !== 1'b1 || res !== 8'd32 || res_ovf !== 1'b0) begin
                    n_bad++; $display("FAIL ovf_2: vld=%b res=%0d ovf=%b expected 1 32 0", res_vld, res, res_ovf);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ins [4];
        logic [7:0] outs [4];
        ins  = '{8'd2, 8'd3, 8'd1, 8'd0};
        outs = '{8'd32, 8'd243, 8'd1, 8'd0};
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, ins[i]);
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b0, 8'd0);
            n_cmp++;
            if (j < 4) begin
                if (res_vld !== 1'b1 || res !== outs[j] || res_ovf !== 1'b0 || busy !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_%0d: vld=%b res=%0d ovf=%b busy=%b expected 1 %0d 0 1",
                                      j, res_vld, res, res_ovf, busy, outs[j]);
                end
            end else if (res_vld !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL b2b_drain: vld=%b busy=%b expected 0 0", res_vld, busy);
            end
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 8'd5);
        drive(1'b1, 1'b1, 8'd7);
        repeat (3) drive(1'b1, 1'b0, 8'd0);
        n_cmp++;
        if (res_vld !== 1'b1 || res !== 8'd53 || res_ovf !== 1'b1) begin
            n_bad++; $display("FAIL stall_first: vld=%b res=%0d ovf=%b expected 1 53 1", res_vld, res, res_ovf);
        end
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            n_cmp++;
            if (res_vld !== 1'b1 || res !== 8'd53 || res_ovf !== 1'b1 || busy !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold_%0d: vld=%b res=%0d ovf=%b busy=%b expected 1 53 1 1",
                                  j, res_vld, res, res_ovf, busy);
            end
        end
        drive(1'b1, 1'b0, 8'd0);
        n_cmp++;
        if (res_vld !== 1'b1 || res !== 8'd167 || res_ovf !== 1'b1) begin
            n_bad++; $display("FAIL stall_second: vld=%b res=%0d ovf=%b expected 1 167 1", res_vld, res, res_ovf);
        end
        drive(1'b1, 1'b0, 8'd0);
        n_cmp++;
        if (res_vld !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL stall_drain: vld=%b busy=%b expected 0 0", res_vld, busy);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 8'd9);
        drive(1'b1, 1'b1, 8'd10);
        drive(1'b1, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b0; n_vld = 1'b0;
        #1;
        q.delete();
        exp_vld = 1'b0; exp_busy = 1'b0;
        n_cmp++;
        if (res_vld !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_assert: vld=%b busy=%b expected 0 0", res_vld, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < P + 2; j++) begin
            drive(1'b1, 1'b0, 8'd0);
            n_cmp++;
            if (res_vld !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL rstmid_stale_%0d: vld=%b busy=%b expected 0 0", j, res_vld, busy);
            end
        end
    endtask

    task automatic test_random();
        bit         en, vld;
        logic [7:0] nn;
        for (int c = 0; c < 420; c++) begin
            en  = (c >= 400) || ($urandom_range(0, 3) != 0);
            vld = (c < 400) && ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 7))
                0:       nn = 8'd0;
                1:       nn = 8'd1;
                2:       nn = 8'd255;
                default: nn = 8'($urandom_range(0, 255));
            endcase
            drive(en, vld, nn);
            n_cmp++;
            if (res_vld !== exp_vld || busy !== exp_busy ||
                (exp_vld && (res !== exp_res || res_ovf !== exp_ovf))) begin
                n_bad++; $display("FAIL random_c%0d: vld=%b res=%0d ovf=%b busy=%b expected %b %0d %b %b",
                                  c, res_vld, res, res_ovf, busy, exp_vld, exp_res, exp_ovf, exp_busy);
            end
        end
    endtask

    task automatic test_pow_small();
        logic [7:0] ins [6];
        logic [7:0] e1, e2;
        logic       o1, o2;
        ins = '{8'd200, 8'd16, 8'd15, 8'd0, 8'd1, 8'd255};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_en  = 1'b1;
            a_vld = (i < 6);
            a_n   = (i < 6) ? ins[i] : 8'd0;
            @(posedge clk);
            #1;
            n_cmp++;
            if (i < 6) begin
                pow_ref(ins[i], 1, e1, o1);
                if (r1_vld !== 1'b1 || r1 !== e1 || r1_ovf !== o1) begin
                    n_bad++; $display("FAIL pow1_%0d: vld=%b res=%0d ovf=%b expected 1 %0d %b",
                                      i, r1_vld, r1, r1_ovf, e1, o1);
                end
            end else if (r1_vld !== 1'b0 || b1 !== 1'b0) begin
                n_bad++; $display("FAIL pow1_idle_%0d: vld=%b busy=%b expected 0 0", i, r1_vld, b1);
            end
            n_cmp++;
            if (i >= 1 && i <= 6) begin
                pow_ref(ins[i-1], 2, e2, o2);
                if (r2_vld !== 1'b1 || r2 !== e2 || r2_ovf !== o2) begin
                    n_bad++; $display("FAIL pow2_%0d: vld=%b res=%0d ovf=%b expected 1 %0d %b",
                                      i, r2_vld, r2, r2_ovf, e2, o2);
                end
            end else if (r2_vld !== 1'b0) begin
                n_bad++; $display("FAIL pow2_idle_%0d: vld=%b expected 0", i, r2_vld);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ovf();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        test_pow_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
